// File: rtl/spi_slave_shift_datapath_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_pkg
// Description : Shared constants for the SPI slave serial front end and its
//               controller: default word width, command opcodes and the
//               bit-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_slave_pkg;

    localparam int         SPI_DATA_WIDTH = 8;
    localparam logic [7:0] SPI_WR_OPCODE  = 8'h02;
    localparam logic [7:0] SPI_RD_OPCODE  = 8'h03;

    // Width of a counter that holds 0..width-1.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_shift_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_shift_datapath_if
// Description : Serial/word-side signal bundle of the SPI slave datapath.
//               slave  modport : datapath side (MOSI/DataSel/Rd_Data in;
//                                tick, opcode flags, rx_word, MISO, cmd_err out)
//               master modport : environment / controller side (mirror)
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_slave_shift_datapath_if #(
    parameter int DATA_WIDTH = spi_slave_pkg::SPI_DATA_WIDTH
);
    logic                  MOSI;
    logic                  DataSel;
    logic [DATA_WIDTH-1:0] Rd_Data;
    logic                  coutner_tick;
    logic                  OP_Wr;
    logic                  OP_Rd;
    logic [DATA_WIDTH-1:0] rx_word;
    logic                  MISO;
    logic                  cmd_err;

    modport slave (
        input  MOSI, DataSel, Rd_Data,
        output coutner_tick, OP_Wr, OP_Rd, rx_word, MISO, cmd_err
    );

    modport master (
        output MOSI, DataSel, Rd_Data,
        input  coutner_tick, OP_Wr, OP_Rd, rx_word, MISO, cmd_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_slave_shift_datapath_bit_counter.sv
`default_nettype none
// ============================================================================
// Module      : spi_bit_counter
// Description : Bit position counter for the SPI slave. Produces the
//               word-boundary tick (combinational, during the last bit) and
//               the command-phase flag (set by reset, cleared by first tick).
// Ports       : clk       - SPI clock (rising edge)
//               rst       - synchronous active-high reset (slave select high)
//               tick      - high while the current bit is the last of a word
//               cmd_phase - high while the current word is the command word
// Revision    : 1.0 - initial release
// ============================================================================
module spi_bit_counter
    import spi_slave_pkg::*;
#(
    parameter int DATA_WIDTH = SPI_DATA_WIDTH,
    parameter int CNT_W      = cnt_w(DATA_WIDTH)
) (
    input  wire  clk,
    input  wire  rst,
    output logic tick,
    output logic cmd_phase
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             cmd_phase_q, cmd_phase_d;
    logic             at_last_w;

    always_comb begin
        at_last_w   = (bit_cnt_q == LAST_BIT);
        // Explicit wrap so non-power-of-two widths still cycle 0..W-1.
        bit_cnt_d   = at_last_w ? '0 : bit_cnt_q + CNT_W'(1);
        cmd_phase_d = cmd_phase_q & ~at_last_w;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            cmd_phase_q <= 1'b1;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            cmd_phase_q <= cmd_phase_d;
        end
    end

    // Suppressed while deselected so no downstream capture fires on a reset edge.
    assign tick      = at_last_w & ~rst;
    assign cmd_phase = cmd_phase_q;

endmodule
`default_nettype wire

// File: rtl/spi_slave_shift_datapath.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_shift_datapath
// Description : SPI slave serial front end. Deserialises MOSI into words,
//               decodes the command word into write/read flags, presents each
//               completed word to downstream capture logic and serialises
//               read data onto MISO.
// Ports       : SCLK - SPI clock, all state updates on the rising edge
//               SS   - synchronous active-high reset (slave deselected)
//               bus  - slave modport: MOSI, DataSel, Rd_Data in;
//                      coutner_tick, OP_Wr, OP_Rd, rx_word, MISO, cmd_err out
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_shift_datapath
    import spi_slave_pkg::*;
#(
    parameter int                    DATA_WIDTH = SPI_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] WR_OPCODE  = DATA_WIDTH'(SPI_WR_OPCODE),
    parameter logic [DATA_WIDTH-1:0] RD_OPCODE  = DATA_WIDTH'(SPI_RD_OPCODE)
) (
    input  wire                          SCLK,
    input  wire                          SS,
    spi_slave_shift_datapath_if.slave    bus
);

    // Only the low W-1 bits of the receive shifter are ever observed: the
    // assembled word is {rx_sr, MOSI}, so the oldest bit falls off here.
    logic [DATA_WIDTH-2:0] rx_sr_q, rx_sr_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic                  cmd_err_q, cmd_err_d;

    logic                  tick_w;
    logic                  cmd_phase_w;
    logic                  cmd_tick_w;
    logic                  match_wr_w;
    logic                  match_rd_w;
    logic [DATA_WIDTH-1:0] rx_word_w;

    spi_bit_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bit_counter (
        .clk       (SCLK),
        .rst       (SS),
        .tick      (tick_w),
        .cmd_phase (cmd_phase_w)
    );

    always_comb begin
        rx_word_w  = {rx_sr_q, bus.MOSI};
        match_wr_w = (rx_word_w == WR_OPCODE);
        match_rd_w = (rx_word_w == RD_OPCODE);
        cmd_tick_w = tick_w & cmd_phase_w;

        rx_sr_d    = rx_word_w[DATA_WIDTH-2:0];

        // Parallel load takes priority over the shift on the same edge.
        if (tick_w && !bus.DataSel) begin
            tx_sr_d = bus.Rd_Data;
        end else begin
            tx_sr_d = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
        end

        cmd_err_d  = cmd_err_q | (cmd_tick_w & ~match_wr_w & ~match_rd_w);
    end

    always_ff @(posedge SCLK) begin
        if (SS) begin
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            rx_sr_q   <= rx_sr_d;
            tx_sr_q   <= tx_sr_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign bus.coutner_tick = tick_w;
    assign bus.OP_Wr        = cmd_tick_w & match_wr_w;
    assign bus.OP_Rd        = cmd_tick_w & match_rd_w;
    assign bus.rx_word      = rx_word_w;
    assign bus.MISO         = tx_sr_q[DATA_WIDTH-1];
    assign bus.cmd_err      = cmd_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_shift_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_shift_datapath
// Description : Self-checking bench for spi_slave_shift_datapath. Inputs are
//               driven on the falling SCLK edge; combinational outputs are
//               sampled 1 time unit later, registered outputs on the falling
//               edge after the update.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_shift_datapath;

    localparam int W = 8;

    typedef struct {
        logic [2:0]   flags;   // {tick, OP_Wr, OP_Rd}
        logic [W-1:0] word;
    } sb_t;

    logic SCLK = 1'b0;
    logic SS   = 1'b1;

    spi_slave_shift_datapath_if #(.DATA_WIDTH(W)) bus ();

    spi_slave_shift_datapath #(.DATA_WIDTH(W)) dut (
        .SCLK (SCLK),
        .SS   (SS),
        .bus  (bus)
    );

    always #5 SCLK = ~SCLK;

    int   n_pass  = 0;
    int   n_total = 0;
    sb_t  sb_q[$];
    logic miso_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One SCLK bit: check pending MISO expectation, drive inputs, check comb outputs.
    task automatic step(input logic mosi, input logic ss_v, input logic ds,
                        input logic [W-1:0] rd, input logic [2:0] exp_flags,
                        input logic [W-1:0] exp_word, input string tag);
        sb_t e;
        @(negedge SCLK);
        if (miso_q.size() > 0) check({tag, "_miso"}, 32'(bus.MISO), 32'(miso_q.pop_front()));
        SS          = ss_v;
        bus.MOSI    = mosi;
        bus.DataSel = ds;
        bus.Rd_Data = rd;
        sb_q.push_back('{flags: exp_flags, word: exp_word});
        #1;
        e = sb_q.pop_front();
        check({tag, "_flags"}, 32'({bus.coutner_tick, bus.OP_Wr, bus.OP_Rd}), 32'(e.flags));
        if (e.flags[2]) check({tag, "_rx_word"}, 32'(bus.rx_word), 32'(e.word));
    endtask

    task automatic send_word(input logic [W-1:0] word, input logic ds, input logic [W-1:0] rd,
                             input logic exp_wr, input logic exp_rd, input string tag);
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) begin
                step(word[W-1-i], 1'b0, ds, rd, {1'b1, exp_wr, exp_rd}, word, tag);
                if (!ds) begin
                    for (int b = W - 1; b >= 0; b--) miso_q.push_back(rd[b]);
                end
            end else begin
                step(word[W-1-i], 1'b0, 1'b1, '0, 3'b000, '0, tag);
            end
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 8'hFF, 3'b000, '0, "reset");
    endtask

    // Registered outputs just after the next rising edge (no extra edge consumed).
    task automatic check_regs(input logic exp_miso, input logic exp_err, input string tag);
        @(posedge SCLK);
        #1;
        check({tag, "_miso"}, 32'(bus.MISO), 32'(exp_miso));
        check({tag, "_cmd_err"}, 32'(bus.cmd_err), 32'(exp_err));
    endtask

    initial begin
        bus.MOSI    = 1'b0;
        bus.DataSel = 1'b1;
        bus.Rd_Data = '0;

        // 1: reset state
        do_reset(2);
        check_regs(1'b0, 1'b0, "t1_reset");

        // 2: write command
        send_word(8'h02, 1'b1, 8'h00, 1'b1, 1'b0, "t2_wr_cmd");
        check_regs(1'b0, 1'b0, "t2_after");

        // 3: read command then data word: no opcode outside command phase
        do_reset(1);
        send_word(8'h03, 1'b1, 8'h00, 1'b0, 1'b1, "t3_rd_cmd");
        send_word(8'h5A, 1'b1, 8'h00, 1'b0, 1'b0, "t3_data");
        check_regs(1'b0, 1'b0, "t3_after");

        // 4: read data serialisation
        do_reset(1);
        send_word(8'h03, 1'b1, 8'h00, 1'b0, 1'b1, "t4_rd_cmd");
        send_word(8'h00, 1'b0, 8'hC3, 1'b0, 1'b0, "t4_load");
        send_word(8'h00, 1'b1, 8'h00, 1'b0, 1'b0, "t4_shift");
        check_regs(1'b0, 1'b0, "t4_drained");

        // 5: bad command sets sticky error, cleared only by reset
        do_reset(1);
        send_word(8'hFF, 1'b1, 8'h00, 1'b0, 1'b0, "t5_bad_cmd");
        check_regs(1'b0, 1'b1, "t5_err_set");
        send_word(8'h02, 1'b1, 8'h00, 1'b0, 1'b0, "t5_later");
        check_regs(1'b0, 1'b1, "t5_err_held");
        do_reset(1);
        check_regs(1'b0, 1'b0, "t5_err_clr");

        // 6: partial word discarded by reset
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, '0, 3'b000, '0, "t6_partial");
        do_reset(1);
        send_word(8'h02, 1'b1, 8'h00, 1'b1, 1'b0, "t6_wr_cmd");
        check_regs(1'b0, 1'b0, "t6_after");

        // Back-to-back read with reset dominating a would-be load edge
        do_reset(1);
        send_word(8'h03, 1'b1, 8'h00, 1'b0, 1'b1, "t7_rd_cmd");
        send_word(8'hA5, 1'b0, 8'h81, 1'b0, 1'b0, "t7_load");
        send_word(8'h3C, 1'b0, 8'h7E, 1'b0, 1'b0, "t7_reload");
        do_reset(1);
        miso_q.delete();
        check_regs(1'b0, 1'b0, "t7_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
